slot_alloc: RTL and testbench
=============================

# slot_alloc

Round-robin tag pool. Holds W tags; hands out a free tag on the allocate port (valid/ready) and accepts returned tags on the free port. The next tag is chosen by a circular find-first-zero search over the occupancy vector, starting below the last tag issued. It sits between request issue logic (consumer of tags) and completion logic (returner of tags).

## Interface
- W, 32: number of tags; power of two, ≥ 4.
- TW, $clog2(W): derived tag width; not overridable.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- alloc_vld_o  out  1  a tag is presented on alloc_tag_o.
- alloc_rdy_i  in  1  consumer accepts the presented tag; fire = alloc_vld_o & alloc_rdy_i.
- alloc_tag_o  out  TW  presented tag.
- free_vld_i  in  1  return free_tag_i to the pool; always accepted.
- free_tag_i  in  TW  tag being returned.
- count_o  out  TW+1  number of tags issued (fired) and not yet freed.
- err_o  out  1  sticky illegal-free flag (see Configuration).

## Operation
- State: occ[W-1:0] occupancy, ptr[TW-1:0] search origin, output register {alloc_vld_o, alloc_tag_o}, count_o, err_o.
- occ bit is set for every issued tag and for the tag held in the output register (reserved).
- Search: candidate = first i with occ[i]==0, scanning ptr-1, ptr-2, …, 0, W-1, …, ptr (mod W). Uses current-cycle occ only; same-cycle frees are not visible.
- Load: on any edge where output register is empty or fire occurs: if a candidate exists, alloc_tag_o←cand, alloc_vld_o←1, occ[cand]←1, ptr←cand; else alloc_vld_o←0.
- Free: on edge with free_vld_i, occ[free_tag_i]←0.
- count_o: +1 on fire, −1 on legal free, unchanged when both occur.
- Full: all W bits set and output register empty → alloc_vld_o=0 until a free.
- alloc_tag_o stable while alloc_vld_o=1 and alloc_rdy_i=0.

## Timing
- Reset (rst_n_i=0 at edge): occ=0, ptr=0, alloc_vld_o=0, alloc_tag_o=0, count_o=0, err_o=0. Reset mid-operation discards all issued tags.
- First edge after reset release: alloc_vld_o=1, alloc_tag_o=W-1.
- Throughput: one allocation per cycle while free tags exist.
- Fire at edge E → next tag presented after edge E.
- Free at edge E → tag eligible for search in cycle E+1 → presentable after edge E+1 (2-cycle free-to-reissue latency).
- Simultaneous fire and free of a different tag: both applied at same edge; freed tag not a candidate that edge.

## Configuration
- SLOT_ALLOC_CHECK_EN defined: a free is illegal if occ[free_tag_i]==0 or free_tag_i equals the reserved tag while alloc_vld_o=1. An illegal free sets err_o (sticky until reset) and leaves occ and count_o unchanged.
- Not defined: frees are trusted. occ bit is cleared and count_o decrements unconditionally. err_o is tied 0. Illegal frees are unsupported.

## Structure
- Package slot_alloc_pkg: default W constant. Tag and count types are declared in-module from W/TW.
- Sub-module slot_alloc_scan: purely combinational circular find-first-zero over occ from ptr.
  - Outputs: one-hot, encoded index, any flag.
- slot_alloc holds all sequential state and the handshake.

## Test plan
- W=4, reset then alloc_rdy_i=1 continuously → tags 3,2,1,0 on consecutive cycles; then alloc_vld_o=0, count_o=4.
- Full pool, free tag 2 at edge E → alloc_vld_o=1, alloc_tag_o=2 after edge E+1; count_o 4→3→4 on fire.
- alloc_rdy_i=0 for 5 cycles with tag 3 presented → alloc_tag_o holds 3, count_o=0; then rdy=1 → tag 2 follows.
- Same edge: fire tag 1 and free tag 3 → count_o unchanged; next tag is 0, then 3.
- SLOT_ALLOC_CHECK_EN: free tag 0 never issued → err_o=1 and stays 1; count_o unchanged; rst_n_i=0 clears it.
- Reset asserted with 3 tags issued → next cycle count_o=0, alloc_vld_o=0; after release, tag 3 presented again.

Source files
------------

// File: rtl/slot_alloc_pkg.sv
// rtl/slot_alloc_pkg.sv - shared constants for the round-robin tag pool
package slot_alloc_pkg;

  localparam int SLOT_ALLOC_W = 32;

endpackage

// File: rtl/slot_alloc_scan.sv
// rtl/slot_alloc_scan.sv - circular find-first-zero over occ, scanning ptr-1 downward and wrapping
module slot_alloc_scan
  import slot_alloc_pkg::*;
#(
  parameter int W  = SLOT_ALLOC_W,
  parameter int TW = $clog2(W)
) (
  input  logic [W-1:0]  occ,
  input  logic [TW-1:0] ptr,
  output logic [W-1:0]  cand_oh,
  output logic [TW-1:0] cand_idx,
  output logic          cand_any
);

  always_comb begin : scan
    logic [TW-1:0] j;
    cand_oh  = '0;
    cand_idx = '0;
    cand_any = 1'b0;
    j        = '0;
    // k = W wraps to offset 0, so ptr itself is the last position examined
    for (int k = 1; k <= W; k++) begin
      j = ptr - TW'(k);
      if (!cand_any && !occ[j]) begin
        cand_any    = 1'b1;
        cand_idx    = j;
        cand_oh[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slot_alloc.sv
// rtl/slot_alloc.sv - round-robin tag pool with valid/ready allocate and trusted/checked free
// Optional illegal-free detection: SLOT_ALLOC_CHECK_EN
module slot_alloc
  import slot_alloc_pkg::*;
#(
  parameter int W = SLOT_ALLOC_W,
  localparam int TW = $clog2(W)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  output logic          alloc_vld_o,
  input  logic          alloc_rdy_i,
  output logic [TW-1:0] alloc_tag_o,
  input  logic          free_vld_i,
  input  logic [TW-1:0] free_tag_i,
  output logic [TW:0]   count_o,
  output logic          err_o
);

  localparam logic [TW:0] COUNT_ONE = 1;

  logic [W-1:0]  occ;
  logic [W-1:0]  occ_nxt;
  logic [TW-1:0] ptr;
  logic [W-1:0]  cand_oh;
  logic [TW-1:0] cand_idx;
  logic          cand_any;
  logic          fire;
  logic          load;
  logic          free_ok;
  logic          free_do;

  slot_alloc_scan #(.W(W), .TW(TW)) u_scan (
    .occ      (occ),
    .ptr      (ptr),
    .cand_oh  (cand_oh),
    .cand_idx (cand_idx),
    .cand_any (cand_any)
  );

  assign fire = alloc_vld_o & alloc_rdy_i;
  assign load = ~alloc_vld_o | fire;

`ifdef SLOT_ALLOC_CHECK_EN
  // The reserved (presented) tag is held in occ but was never handed out, so freeing it is illegal
  assign free_ok = occ[free_tag_i] & ~(alloc_vld_o & (free_tag_i == alloc_tag_o));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_o <= 1'b0;
    end else if (free_vld_i && !free_ok) begin
      err_o <= 1'b1;
    end
  end
`else
  assign free_ok = 1'b1;
  assign err_o   = 1'b0;
`endif

  assign free_do = free_vld_i & free_ok;

  always_comb begin
    occ_nxt = occ;
    if (free_do) begin
      occ_nxt[free_tag_i] = 1'b0;
    end
    if (load && cand_any) begin
      occ_nxt = occ_nxt | cand_oh;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      occ         <= '0;
      ptr         <= '0;
      alloc_vld_o <= 1'b0;
      alloc_tag_o <= '0;
      count_o     <= '0;
    end else begin
      occ <= occ_nxt;
      if (load) begin
        alloc_vld_o <= cand_any;
        if (cand_any) begin
          alloc_tag_o <= cand_idx;
          ptr         <= cand_idx;
        end
      end
      case ({fire, free_do})
        2'b10:   count_o <= count_o + COUNT_ONE;
        2'b01:   count_o <= count_o - COUNT_ONE;
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: tb/tb_slot_alloc.sv
// tb/tb_slot_alloc.sv - scoreboard bench for slot_alloc with W=4
module tb_slot_alloc;

  localparam int W  = 4;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alloc_vld;
  logic          alloc_rdy = 1'b0;
  logic [TW-1:0] alloc_tag;
  logic          free_vld = 1'b0;
  logic [TW-1:0] free_tag = '0;
  logic [TW:0]   count;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;
  int sb[$];
  int exp_tag;

  slot_alloc #(.W(W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .alloc_vld_o (alloc_vld),
    .alloc_rdy_i (alloc_rdy),
    .alloc_tag_o (alloc_tag),
    .free_vld_i  (free_vld),
    .free_tag_i  (free_tag),
    .count_o     (count),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    alloc_rdy = 1'b0;
    free_vld = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (alloc_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %0d expected 0", alloc_vld); end
    n_cmp++; if (alloc_tag !== 2'd0) begin n_bad++; $display("FAIL reset_tag: got %0d expected 0", alloc_tag); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0d expected 0", err); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream;
    sb.push_back(3); sb.push_back(2); sb.push_back(1); sb.push_back(0);
    tick();
    alloc_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_tag = (sb.size() != 0) ? sb.pop_front() : -1;
      n_cmp++; if (alloc_vld !== 1'b1 || int'(alloc_tag) != exp_tag) begin
        n_bad++; $display("FAIL stream_tag%0d: got vld=%0d tag=%0d expected vld=1 tag=%0d", i, alloc_vld, alloc_tag, exp_tag);
      end
      tick();
    end
    n_cmp++; if (alloc_vld !== 1'b0) begin n_bad++; $display("FAIL stream_empty_vld: got %0d expected 0", alloc_vld); end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL stream_count: got %0d expected 4", count); end
  endtask

  task automatic test_full_free;
    free_vld = 1'b1;
    free_tag = 2'd2;
    tick();
    free_vld = 1'b0;
    n_cmp++; if (alloc_vld !== 1'b0) begin n_bad++; $display("FAIL free_lat_vld: got %0d expected 0", alloc_vld); end
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL free_count: got %0d expected 3", count); end
    sb.push_back(2);
    tick();
    exp_tag = (sb.size() != 0) ? sb.pop_front() : -1;
    n_cmp++; if (alloc_vld !== 1'b1 || int'(alloc_tag) != exp_tag) begin
      n_bad++; $display("FAIL free_reissue: got vld=%0d tag=%0d expected vld=1 tag=%0d", alloc_vld, alloc_tag, exp_tag);
    end
    tick();
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL refire_count: got %0d expected 4", count); end
    n_cmp++; if (alloc_vld !== 1'b0) begin n_bad++; $display("FAIL refire_vld: got %0d expected 0", alloc_vld); end
  endtask

  task automatic test_hold;
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (alloc_vld !== 1'b1 || alloc_tag !== 2'd3 || count !== 3'd0) begin
        n_bad++; $display("FAIL hold%0d: got vld=%0d tag=%0d count=%0d expected vld=1 tag=3 count=0", i, alloc_vld, alloc_tag, count);
      end
      tick();
    end
    sb.push_back(3); sb.push_back(2);
    alloc_rdy = 1'b1;
    exp_tag = (sb.size() != 0) ? sb.pop_front() : -1;
    n_cmp++; if (int'(alloc_tag) != exp_tag) begin n_bad++; $display("FAIL hold_release: got %0d expected %0d", alloc_tag, exp_tag); end
    tick();
    alloc_rdy = 1'b0;
    exp_tag = (sb.size() != 0) ? sb.pop_front() : -1;
    n_cmp++; if (alloc_vld !== 1'b1 || int'(alloc_tag) != exp_tag) begin
      n_bad++; $display("FAIL hold_next: got vld=%0d tag=%0d expected vld=1 tag=%0d", alloc_vld, alloc_tag, exp_tag);
    end
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL hold_count: got %0d expected 1", count); end
  endtask

  task automatic test_same_edge;
    do_reset();
    tick();
    sb.push_back(3); sb.push_back(2); sb.push_back(1); sb.push_back(0); sb.push_back(3);
    alloc_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        free_vld = 1'b1;
        free_tag = 2'd3;
      end
      exp_tag = (sb.size() != 0) ? sb.pop_front() : -1;
      n_cmp++; if (alloc_vld !== 1'b1 || int'(alloc_tag) != exp_tag) begin
        n_bad++; $display("FAIL same_edge_tag%0d: got vld=%0d tag=%0d expected vld=1 tag=%0d", i, alloc_vld, alloc_tag, exp_tag);
      end
      tick();
      free_vld = 1'b0;
      if (i == 2) begin
        n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL same_edge_count: got %0d expected 2", count); end
      end
    end
    alloc_rdy = 1'b0;
    n_cmp++; if (count !== 3'd4 || alloc_vld !== 1'b0) begin
      n_bad++; $display("FAIL same_edge_final: got count=%0d vld=%0d expected count=4 vld=0", count, alloc_vld);
    end
  endtask

  task automatic test_err;
    do_reset();
    tick();
`ifdef SLOT_ALLOC_CHECK_EN
    free_vld = 1'b1;
    free_tag = 2'd0;
    tick();
    free_vld = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %0d expected 1", err); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL err_count: got %0d expected 0", count); end
    tick(); tick(); tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %0d expected 1", err); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %0d expected 0", err); end
`else
    alloc_rdy = 1'b1;
    tick();
    alloc_rdy = 1'b0;
    free_vld = 1'b1;
    free_tag = 2'd3;
    tick();
    free_vld = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_tied: got %0d expected 0", err); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL trusted_free_count: got %0d expected 0", count); end
`endif
  endtask

  task automatic test_reset_mid;
    do_reset();
    tick();
    sb.push_back(3); sb.push_back(2); sb.push_back(1);
    alloc_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_tag = (sb.size() != 0) ? sb.pop_front() : -1;
      n_cmp++; if (int'(alloc_tag) != exp_tag) begin n_bad++; $display("FAIL mid_tag%0d: got %0d expected %0d", i, alloc_tag, exp_tag); end
      tick();
    end
    alloc_rdy = 1'b0;
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL mid_count: got %0d expected 3", count); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (count !== 3'd0 || alloc_vld !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset: got count=%0d vld=%0d expected count=0 vld=0", count, alloc_vld);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (alloc_vld !== 1'b1 || alloc_tag !== 2'd3) begin
      n_bad++; $display("FAIL mid_restart: got vld=%0d tag=%0d expected vld=1 tag=3", alloc_vld, alloc_tag);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_free();
    test_hold();
    test_same_edge();
    test_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
